// File: rtl/vga_timing_gen.sv
// Raster timing generator: cascaded line/frame counters, registered active window,
// start pulses, frame counter, and a programmable-depth sync/blank delay line.
module vga_timing_gen #(
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter bit SYNC_POL = 1'b0,
    parameter int PIPE_DLY = 1
) (
    input  logic       vga_clk,
    input  logic       rst_n,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       blank_n,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_cnt
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

    // Window bounds held at 11 bits so an end bound of 1024 stays representable.
    localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_SYNC_E  = 11'(H_SYNC);
    localparam logic [10:0] V_SYNC_E  = 11'(V_SYNC);
    localparam logic [10:0] H_ACT_BEG = 11'(H_SYNC + H_BP);
    localparam logic [10:0] H_ACT_END = 11'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [10:0] V_ACT_BEG = 11'(V_SYNC + V_BP);
    localparam logic [10:0] V_ACT_END = 11'(V_SYNC + V_BP + V_ACTIVE);

    logic [9:0] h_cnt, v_cnt;
    logic [9:0] h_nxt, v_nxt;
    logic       h_wrap, frame_wrap;
    logic       active_nxt, hs_nxt, vs_nxt;
    logic       hs_p0, vs_p0;

    // Everything registered below is derived from the next-state counts so it
    // lines up with pixel_x/pixel_y in the same cycle.
    always_comb begin
        h_wrap     = (h_cnt == H_LAST);
        h_nxt      = h_wrap ? 10'd0 : h_cnt + 10'd1;
        v_nxt      = v_cnt;
        if (h_wrap) begin
            v_nxt = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
        end
        frame_wrap = h_wrap && (v_cnt == V_LAST);
        active_nxt = ({1'b0, h_nxt} >= H_ACT_BEG) && ({1'b0, h_nxt} < H_ACT_END) &&
                     ({1'b0, v_nxt} >= V_ACT_BEG) && ({1'b0, v_nxt} < V_ACT_END);
        hs_nxt     = ({1'b0, h_nxt} < H_SYNC_E) ? SYNC_POL : ~SYNC_POL;
        vs_nxt     = ({1'b0, v_nxt} < V_SYNC_E) ? SYNC_POL : ~SYNC_POL;
    end

    // Stage p0: counters and raw timing flags
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt       <= 10'd0;
            v_cnt       <= 10'd0;
            video_on    <= 1'b0;
            hs_p0       <= ~SYNC_POL;
            vs_p0       <= ~SYNC_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= 8'd0;
        end else begin
            h_cnt       <= h_nxt;
            v_cnt       <= v_nxt;
            video_on    <= active_nxt;
            hs_p0       <= hs_nxt;
            vs_p0       <= vs_nxt;
            line_start  <= h_wrap;
            frame_start <= frame_wrap;
            if (frame_wrap) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

    assign pixel_x = h_cnt;
    assign pixel_y = v_cnt;

    // Stage p1..pN: delay line matching the renderer's registered RGB latency
    generate
        if (PIPE_DLY == 0) begin : g_no_dly
            assign hsync   = hs_p0;
            assign vsync   = vs_p0;
            assign blank_n = video_on;
        end else begin : g_dly
            logic [2:0] dly_p [PIPE_DLY];

            always_ff @(posedge vga_clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < PIPE_DLY; i++) begin
                        dly_p[i] <= {~SYNC_POL, ~SYNC_POL, 1'b0};
                    end
                end else begin
                    dly_p[0] <= {hs_p0, vs_p0, video_on};
                    for (int i = 1; i < PIPE_DLY; i++) begin
                        dly_p[i] <= dly_p[i-1];
                    end
                end
            end

            assign hsync   = dly_p[PIPE_DLY-1][2];
            assign vsync   = dly_p[PIPE_DLY-1][1];
            assign blank_n = dly_p[PIPE_DLY-1][0];
        end
    endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default, delayed/inverted, tiny raster)
// compared every cycle against an edge-count model, plus fixed vectors and reset sequences.
module tb_vga_timing_gen;

    localparam int SH_S = 2, SH_B = 1, SH_A = 4, SH_F = 1;
    localparam int SV_S = 1, SV_B = 1, SV_A = 2, SV_F = 1;

    logic clk = 1'b0;
    logic rst_a = 1'b0, rst_b = 1'b0, rst_c = 1'b0;
    int   n_a, n_b, n_c;
    int   errors = 0;
    int   checks = 0;
    bit   meas_on = 1'b1;

    logic [9:0] px_a, py_a, px_b, py_b, px_c, py_c;
    logic       von_a, hs_a, vs_a, bn_a, ls_a, fs_a;
    logic       von_b, hs_b, vs_b, bn_b, ls_b, fs_b;
    logic       von_c, hs_c, vs_c, bn_c, ls_c, fs_c;
    logic [7:0] fc_a, fc_b, fc_c;
    logic [33:0] got_a, got_b, got_c;

    always #5 clk = ~clk;

    vga_timing_gen dut_a (
        .vga_clk(clk), .rst_n(rst_a), .pixel_x(px_a), .pixel_y(py_a), .video_on(von_a),
        .hsync(hs_a), .vsync(vs_a), .blank_n(bn_a), .line_start(ls_a),
        .frame_start(fs_a), .frame_cnt(fc_a));

    vga_timing_gen #(.SYNC_POL(1'b1), .PIPE_DLY(2)) dut_b (
        .vga_clk(clk), .rst_n(rst_b), .pixel_x(px_b), .pixel_y(py_b), .video_on(von_b),
        .hsync(hs_b), .vsync(vs_b), .blank_n(bn_b), .line_start(ls_b),
        .frame_start(fs_b), .frame_cnt(fc_b));

    vga_timing_gen #(.H_SYNC(SH_S), .H_BP(SH_B), .H_ACTIVE(SH_A), .H_FP(SH_F),
                     .V_SYNC(SV_S), .V_BP(SV_B), .V_ACTIVE(SV_A), .V_FP(SV_F),
                     .SYNC_POL(1'b0), .PIPE_DLY(0)) dut_c (
        .vga_clk(clk), .rst_n(rst_c), .pixel_x(px_c), .pixel_y(py_c), .video_on(von_c),
        .hsync(hs_c), .vsync(vs_c), .blank_n(bn_c), .line_start(ls_c),
        .frame_start(fs_c), .frame_cnt(fc_c));

    assign got_a = {px_a, py_a, von_a, hs_a, vs_a, bn_a, ls_a, fs_a, fc_a};
    assign got_b = {px_b, py_b, von_b, hs_b, vs_b, bn_b, ls_b, fs_b, fc_b};
    assign got_c = {px_c, py_c, von_c, hs_c, vs_c, bn_c, ls_c, fs_c, fc_c};

    localparam logic [33:0] RESET_LO = {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    localparam logic [33:0] RESET_HI = {10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};

    // Edges seen since each instance's reset was released.
    always @(posedge clk or negedge rst_a) if (!rst_a) n_a <= 0; else n_a <= n_a + 1;
    always @(posedge clk or negedge rst_b) if (!rst_b) n_b <= 0; else n_b <= n_b + 1;
    always @(posedge clk or negedge rst_c) if (!rst_c) n_c <= 0; else n_c <= n_c + 1;

    // Expected outputs after n edges, straight from the raster arithmetic.
    function automatic logic [33:0] model(input int n, input int hsw, input int hbp,
                                          input int hac, input int hfp, input int vsw,
                                          input int vbp, input int vac, input int vfp,
                                          input bit pol, input int dly);
        int ht, vt, h, v, m, hm, vm;
        logic von_n, hs_d, vs_d, bn_d, ls, fs;
        ht = hsw + hbp + hac + hfp;
        vt = vsw + vbp + vac + vfp;
        h  = n % ht;
        v  = (n / ht) % vt;
        von_n = (n != 0) && (h >= hsw + hbp) && (h < hsw + hbp + hac) &&
                (v >= vsw + vbp) && (v < vsw + vbp + vac);
        m  = (n >= dly) ? n - dly : 0;
        hm = m % ht;
        vm = (m / ht) % vt;
        hs_d = (m == 0) ? ~pol : ((hm < hsw) ? pol : ~pol);
        vs_d = (m == 0) ? ~pol : ((vm < vsw) ? pol : ~pol);
        bn_d = (m != 0) && (hm >= hsw + hbp) && (hm < hsw + hbp + hac) &&
               (vm >= vsw + vbp) && (vm < vsw + vbp + vac);
        ls = (n != 0) && (h == 0);
        fs = ls && (v == 0);
        return {10'(h), 10'(v), von_n, hs_d, vs_d, bn_d, ls, fs, 8'((n / (ht * vt)) % 256)};
    endfunction

    task automatic chk(input string name, input int tag, input logic [33:0] got,
                       input logic [33:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at n=%0d: got=%h expected=%h", name, tag, got, exp);
        end
    endtask

    task automatic wait_n(input int sel, input int target);
        int cur;
        for (int k = 0; k < 100000; k++) begin
            @(negedge clk);
            cur = (sel == 0) ? n_a : (sel == 1) ? n_b : n_c;
            if (cur == target) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_n sel=%0d target=%0d timed out", sel, target);
    endtask

    typedef struct {
        int         n;
        logic [9:0] px, py;
        logic       von, hs, vs, bn, ls;
    } vec_t;

    vec_t tbl[$];

    // Every-cycle scoreboard for all three instances.
    initial begin
        forever begin
            @(negedge clk);
            chk("sb_a", n_a, got_a, model(n_a, 96, 48, 640, 16, 2, 33, 480, 10, 1'b0, 1));
            chk("sb_b", n_b, got_b, model(n_b, 96, 48, 640, 16, 2, 33, 480, 10, 1'b1, 2));
            chk("sb_c", n_c, got_c, model(n_c, SH_S, SH_B, SH_A, SH_F, SV_S, SV_B, SV_A, SV_F,
                                          1'b0, 0));
        end
    end

    // Line/frame periods and vsync run length on the tiny raster.
    initial begin
        int last_ls = 0, last_fs = 0, run = 0;
        forever begin
            @(negedge clk);
            if (meas_on && rst_c) begin
                if (ls_c) begin
                    chk("line_len", n_c, 34'(n_c - last_ls), 34'(8));
                    last_ls = n_c;
                end
                if (fs_c) begin
                    chk("frame_len", n_c, 34'(n_c - last_fs), 34'(40));
                    last_fs = n_c;
                end
                if (vs_c == 1'b0) begin
                    run++;
                end else begin
                    if (run > 0 && n_c > 40) chk("vsync_run", n_c, 34'(run), 34'(8));
                    run = 0;
                end
            end
        end
    end

    initial begin
        #(10 * 200000);
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        if ((SH_S + SH_B + SH_A + SH_F > 1024) || (96 + 48 + 640 + 16 > 1024) ||
            (SV_S + SV_B + SV_A + SV_F > 1024) || (2 + 33 + 480 + 10 > 1024)) begin
            $display("FAIL raster totals exceed 1024");
            $fatal(1, "bad parameters");
        end

        //           n      px     py     von   hs    vs    bn    ls
        tbl.push_back('{1,     10'd1,   10'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{2,     10'd2,   10'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{96,    10'd96,  10'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{97,    10'd97,  10'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{800,   10'd0,   10'd1,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{801,   10'd1,   10'd1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1600,  10'd0,   10'd2,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1601,  10'd1,   10'd2,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{27344, 10'd144, 10'd34, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{28143, 10'd143, 10'd35, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{28144, 10'd144, 10'd35, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{28145, 10'd145, 10'd35, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{28783, 10'd783, 10'd35, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{28784, 10'd784, 10'd35, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{28785, 10'd785, 10'd35, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{29200, 10'd400, 10'd36, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0});

        repeat (10) @(negedge clk);
        chk("reset_a", 0, got_a, RESET_LO);
        chk("reset_b", 0, got_b, RESET_HI);
        chk("reset_c", 0, got_c, RESET_LO);
        rst_a = 1'b1;
        rst_b = 1'b1;
        rst_c = 1'b1;

        fork
            begin
                foreach (tbl[i]) begin
                    wait_n(0, tbl[i].n);
                    chk("vec_a", tbl[i].n,
                        34'({px_a, py_a, von_a, hs_a, vs_a, bn_a, ls_a}),
                        34'({tbl[i].px, tbl[i].py, tbl[i].von, tbl[i].hs, tbl[i].vs,
                             tbl[i].bn, tbl[i].ls}));
                end
                @(posedge clk);
                #2 rst_a = 1'b0;
                #1 chk("midreset_async", n_a, got_a, RESET_LO);
                repeat (3) @(negedge clk);
                rst_a = 1'b1;
                @(negedge clk);
                chk("midreset_resume", n_a, 34'({px_a, py_a, fc_a, ls_a}),
                    34'({10'd1, 10'd0, 8'd0, 1'b0}));
                repeat (50) @(negedge clk);
            end
            begin
                wait_n(1, 801);
                chk("dly2_hs_before", n_b, 34'({px_b, hs_b}), 34'({10'd1, 1'b0}));
                wait_n(1, 802);
                chk("dly2_hs_rise", n_b, 34'({px_b, hs_b}), 34'({10'd2, 1'b1}));
                wait_n(1, 1000);
                chk("pol_hi_vs", n_b, 34'(vs_b), 34'(1));
                wait_n(1, 2000);
                chk("pol_hi_vs_off", n_b, 34'(vs_b), 34'(0));
                wait_n(1, 28144);
                chk("dly2_von", n_b, 34'({von_b, bn_b}), 34'({1'b1, 1'b0}));
                wait_n(1, 28145);
                chk("dly2_bn_before", n_b, 34'(bn_b), 34'(0));
                wait_n(1, 28146);
                chk("dly2_bn_rise", n_b, 34'(bn_b), 34'(1));
            end
            begin
                wait_n(2, 39);
                chk("wrap_pre", n_c, 34'({px_c, py_c, ls_c, fs_c, fc_c}),
                    34'({10'd7, 10'd4, 1'b0, 1'b0, 8'd0}));
                wait_n(2, 40);
                chk("wrap_post", n_c, 34'({px_c, py_c, ls_c, fs_c, fc_c}),
                    34'({10'd0, 10'd0, 1'b1, 1'b1, 8'd1}));
                wait_n(2, 10239);
                chk("fc_255", n_c, 34'(fc_c), 34'(255));
                wait_n(2, 10240);
                chk("fc_wrap", n_c, 34'({fs_c, fc_c}), 34'({1'b1, 8'd0}));
                wait_n(2, 10400);
                chk("fc_260", n_c, 34'({px_c, py_c, fc_c}), 34'({10'd0, 10'd0, 8'd4}));
                meas_on = 1'b0;
                for (int r = 0; r < 16; r++) begin
                    repeat ($urandom_range(3, 60)) @(negedge clk);
                    @(posedge clk);
                    #($urandom_range(1, 3)) rst_c = 1'b0;
                    #1 chk("rand_reset_async", r, got_c, RESET_LO);
                    repeat ($urandom_range(1, 4)) @(negedge clk);
                    rst_c = 1'b1;
                    @(negedge clk);
                    chk("rand_reset_resume", r, 34'({px_c, py_c, fc_c}),
                        34'({10'd1, 10'd0, 8'd0}));
                end
            end
        join

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
